// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu control sequencer: state encoding,
// instruction class encodings, instruction field positions and the
// bundle of control strobes the sequencer drives.
// Ports: none (package).
package cpu_pkg;

  localparam int STATE_W = 3;
  localparam int INSTR_W = 32;

  // Instruction field positions
  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 26;
  localparam int SWI_HI   = 25;
  localparam int SWI_LO   = 24;
  localparam int LBIT     = 20;

  localparam logic [3:0] COND_NV = 4'hF;
  localparam logic [1:0] SWI_PAT = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEM_ADDR   = 3'd3,
    S_MEM_ACCESS = 3'd4,
    S_MEM_WB     = 3'd5,
    S_RESTORE    = 3'd6,
    S_HALT       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_LS  = 2'b01,
    CLS_BR  = 2'b10,
    CLS_SYS = 2'b11
  } cls_t;

  // All datapath strobes in one word so they can be defaulted/cleared together.
  typedef struct packed {
    logic addrwrite;
    logic addrin1;
    logic addrin2;
    logic addrout1;
    logic increment_enable;
    logic instrin;
    logic memwrite;
    logic regwrite;
    logic wbmem;
    logic alupc;
  } ctrl_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bundle between the control sequencer and the cpu datapath.
// Ports: instr/stall into the sequencer; c_* strobes, state, halted out.
// With CPU_CTRL_PERF_EN defined, cycle_count/instr_count are also carried.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               c_addrwrite;
  logic               c_addrin1;
  logic               c_addrin2;
  logic               c_addrout1;
  logic               c_incrementEnable;
  logic               c_instrin;
  logic               c_memwrite;
  logic               c_regwrite;
  logic               c_wbmem;
  logic               c_alupc;
  logic [STATE_W-1:0] state;
  logic               halted;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0]        cycle_count;
  logic [31:0]        instr_count;
`endif

  // master = sequencer, slave = datapath side
  modport master (
    input  instr, stall,
    output c_addrwrite, c_addrin1, c_addrin2, c_addrout1, c_incrementEnable,
           c_instrin, c_memwrite, c_regwrite, c_wbmem, c_alupc, state, halted
`ifdef CPU_CTRL_PERF_EN
    , output cycle_count, instr_count
`endif
  );

  modport slave (
    output instr, stall,
    input  c_addrwrite, c_addrin1, c_addrin2, c_addrout1, c_incrementEnable,
           c_instrin, c_memwrite, c_regwrite, c_wbmem, c_alupc, state, halted
`ifdef CPU_CTRL_PERF_EN
    , input cycle_count, instr_count
`endif
  );

endinterface

// File: rtl/cpu_control_unit_instr_classifier.sv
// Combinational instruction classifier for the control sequencer.
// Ports: instr in; cls, is_load, is_nop, is_halt out. No latency.
// Never-condition instructions are NOPs regardless of class.
module instr_classifier
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output cls_t               cls,
  output logic               is_load,
  output logic               is_nop,
  output logic               is_halt
);

  logic never;
  logic swi_pat;

  assign never   = (instr[COND_HI:COND_LO] == COND_NV);
  assign cls     = cls_t'(instr[CLASS_HI:CLASS_LO]);
  assign swi_pat = (instr[SWI_HI:SWI_LO] == SWI_PAT);
  assign is_load = instr[LBIT];
  assign is_halt = !never && (cls == CLS_SYS) && swi_pat;
  assign is_nop  = never || ((cls == CLS_SYS) && !swi_pat);

  // Operand/immediate fields are irrelevant to sequencing.
  logic unused_fields;
  assign unused_fields = ^{instr[23:21], instr[19:0]};

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving all cpu datapath strobes.
// Ports: clk, rst (async, active-high), bus (master modport: instr/stall in,
// c_* strobes, state, halted out). Strobes decode state+instr combinationally;
// stall freezes state and zeroes strobes. Optional CPU_CTRL_PERF_EN adds
// cycle_count/instr_count performance counters.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cpu_control_unit_if.master   bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  cls_t   cls;
  logic   is_load;
  logic   is_nop;
  logic   is_halt;

  instr_classifier u_classifier (
    .instr   (bus.instr),
    .cls     (cls),
    .is_load (is_load),
    .is_nop  (is_nop),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.addrout1 = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.instrin          = 1'b1;
        ctrl.addrwrite        = 1'b1;
        ctrl.addrin2          = 1'b1;
        ctrl.increment_enable = 1'b1;
        state_d               = S_EXECUTE;
      end
      S_EXECUTE: begin
        // Halt and NOP checks come first so a never-condition load/store
        // does not start a memory sequence.
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_nop) begin
          state_d = S_FETCH;
        end else begin
          case (cls)
            CLS_DP: begin
              ctrl.regwrite = 1'b1;
              state_d       = S_FETCH;
            end
            CLS_BR: begin
              ctrl.addrwrite = 1'b1;
              ctrl.addrin1   = 1'b1;
              state_d        = S_FETCH;
            end
            CLS_LS:  state_d = S_MEM_ADDR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        ctrl.addrwrite = 1'b1;
        ctrl.addrin1   = 1'b1;
        state_d        = S_MEM_ACCESS;
      end
      S_MEM_ACCESS: begin
        ctrl.addrout1 = 1'b1;
        ctrl.memwrite = !is_load;
        state_d       = is_load ? S_MEM_WB : S_RESTORE;
      end
      S_MEM_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.wbmem    = 1'b1;
        state_d       = S_RESTORE;
      end
      S_RESTORE: begin
        ctrl.addrwrite = 1'b1;
        ctrl.addrin1   = 1'b1;
        ctrl.alupc     = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Stall holds the current state so its strobes re-issue once released.
    if (bus.stall) begin
      ctrl    = '0;
      state_d = state_q;
    end

    // Strobes stay quiet for the whole reset, including the asserting cycle.
    if (rst) ctrl = '0;
  end

  assign bus.c_addrwrite       = ctrl.addrwrite;
  assign bus.c_addrin1         = ctrl.addrin1;
  assign bus.c_addrin2         = ctrl.addrin2;
  assign bus.c_addrout1        = ctrl.addrout1;
  assign bus.c_incrementEnable = ctrl.increment_enable;
  assign bus.c_instrin         = ctrl.instrin;
  assign bus.c_memwrite        = ctrl.memwrite;
  assign bus.c_regwrite        = ctrl.regwrite;
  assign bus.c_wbmem           = ctrl.wbmem;
  assign bus.c_alupc           = ctrl.alupc;
  assign bus.state             = state_q;
  assign bus.halted            = (state_q == S_HALT) && !rst;

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (!bus.stall) begin
      if (state_q != S_HALT)    cycle_q <= cycle_q + 32'd1;
      if (state_q == S_EXECUTE) instr_q <= instr_q + 32'd1;
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic clk;
  logic rst;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe word: {aw, a1, a2, ao, inc, ii, mw, rw, wb, pc, halted}
  localparam logic [10:0] X_NONE = 11'b00000000000;
  localparam logic [10:0] X_FE   = 11'b00010000000;
  localparam logic [10:0] X_DE   = 11'b10101100000;
  localparam logic [10:0] X_DP   = 11'b00000001000;
  localparam logic [10:0] X_BR   = 11'b11000000000;
  localparam logic [10:0] X_MA   = 11'b11000000000;
  localparam logic [10:0] X_LD   = 11'b00010000000;
  localparam logic [10:0] X_ST   = 11'b00010010000;
  localparam logic [10:0] X_WB   = 11'b00000001100;
  localparam logic [10:0] X_RS   = 11'b11000000010;
  localparam logic [10:0] X_HLT  = 11'b00000000001;

  localparam logic [31:0] I_DP   = 32'hE0810002;
  localparam logic [31:0] I_LD   = 32'hE5910000;
  localparam logic [31:0] I_ST   = 32'hE5810000;
  localparam logic [31:0] I_BR   = 32'hEA000000;
  localparam logic [31:0] I_NV   = 32'hF5910000;
  localparam logic [31:0] I_SYS  = 32'hEE000000;
  localparam logic [31:0] I_SWI  = 32'hEF000000;

  typedef struct {
    logic [31:0] instr;
    logic        stall;
    logic [2:0]  exp_state;
    logic [10:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic logic [10:0] observed();
    return {bus.c_addrwrite, bus.c_addrin1, bus.c_addrin2, bus.c_addrout1,
            bus.c_incrementEnable, bus.c_instrin, bus.c_memwrite,
            bus.c_regwrite, bus.c_wbmem, bus.c_alupc, bus.halted};
  endfunction

  task automatic add(input logic [31:0] i, input logic s,
                     input logic [2:0] st, input logic [10:0] x);
    vec_t v;
    v.instr = i; v.stall = s; v.exp_state = st; v.exp_out = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] st,
                       input logic [10:0] x);
    n_vec++;
    if (bus.state !== st || observed() !== x) begin
      n_bad++;
      $display("FAIL %s: got state=%0d strobes=%b, required state=%0d strobes=%b",
               name, bus.state, observed(), st, x);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // DP: 3 cycles
    add(I_DP, 0, 0, X_FE); add(I_DP, 0, 1, X_DE); add(I_DP, 0, 2, X_DP);
    // Load: 7 cycles, no memwrite
    add(I_LD, 0, 0, X_FE); add(I_LD, 0, 1, X_DE); add(I_LD, 0, 2, X_NONE);
    add(I_LD, 0, 3, X_MA); add(I_LD, 0, 4, X_LD); add(I_LD, 0, 5, X_WB);
    add(I_LD, 0, 6, X_RS);
    // Store: 6 cycles, one memwrite
    add(I_ST, 0, 0, X_FE); add(I_ST, 0, 1, X_DE); add(I_ST, 0, 2, X_NONE);
    add(I_ST, 0, 3, X_MA); add(I_ST, 0, 4, X_ST); add(I_ST, 0, 6, X_RS);
    // Branch
    add(I_BR, 0, 0, X_FE); add(I_BR, 0, 1, X_DE); add(I_BR, 0, 2, X_BR);
    // Never-condition load is a NOP
    add(I_NV, 0, 0, X_FE); add(I_NV, 0, 1, X_DE); add(I_NV, 0, 2, X_NONE);
    // Class 11 without SWI pattern is a NOP
    add(I_SYS, 0, 0, X_FE); add(I_SYS, 0, 1, X_DE); add(I_SYS, 0, 2, X_NONE);
    // DP with one stall cycle in DECODE
    add(I_DP, 0, 0, X_FE); add(I_DP, 1, 1, X_NONE); add(I_DP, 0, 1, X_DE);
    add(I_DP, 0, 2, X_DP);
    // Load stalled 3 cycles in MEM_ACCESS
    add(I_LD, 0, 0, X_FE); add(I_LD, 0, 1, X_DE); add(I_LD, 0, 2, X_NONE);
    add(I_LD, 0, 3, X_MA);
    add(I_LD, 1, 4, X_NONE); add(I_LD, 1, 4, X_NONE); add(I_LD, 1, 4, X_NONE);
    add(I_LD, 0, 4, X_LD); add(I_LD, 0, 5, X_WB); add(I_LD, 0, 6, X_RS);
    // SWI then 10 halted cycles, stall toggling has no effect
    add(I_SWI, 0, 0, X_FE); add(I_SWI, 0, 1, X_DE); add(I_SWI, 0, 2, X_NONE);
    for (int k = 0; k < 10; k++) add(I_SWI, logic'(k % 2), 7, X_HLT);

    // Reset held 2 cycles, strobes quiet throughout
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.instr = I_DP;
    @(negedge clk);
    check("rst_cycle1", 3'd0, X_NONE);
    @(negedge clk);
    check("rst_cycle2", 3'd0, X_NONE);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.instr = vecs[i].instr;
      bus.stall = vecs[i].stall;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_out);
      @(negedge clk);
    end

    // Reset out of HALT: async, immediately quiet
    bus.stall = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_from_halt", 3'd0, X_NONE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fetch_after_halt_rst", 3'd0, X_FE);

    // Load aborted by reset in MEM_ADDR, with stall asserted as well
    bus.instr = I_LD;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_abort_mem_addr", 3'd3, X_MA);
    rst       = 1'b1;
    bus.stall = 1'b1;
    #1;
    check("abort_mem_addr", 3'd0, X_NONE);
    @(negedge clk);
    check("abort_hold", 3'd0, X_NONE);
    rst       = 1'b0;
    bus.stall = 1'b0;
    #1;
    check("fetch_after_abort", 3'd0, X_FE);
    @(negedge clk);
    #1;
    check("decode_after_abort", 3'd1, X_DE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
